// File: rtl/adc_ctrl_pkg.sv
// Shared types and constants for the ADC read controller.
//   adc_ctrl_state_t : controller FSM states
//   ADC_VALUE_WIDTH  : width of the ADC conversion result
package adc_ctrl_pkg;

  localparam int unsigned ADC_VALUE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    READ,
    RECOVER
  } adc_ctrl_state_t;

endpackage

// File: rtl/adc_read_ctrl.sv
// Digital-side controller for the external ADC. Powers the ADC up, waits for it to settle,
// raises adc_read, captures adc_value on the completion pulse and reports done or timeout.
//
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   start                    : single-cycle request for one conversion (ignored while busy)
//   abort                    : cancel the conversion in progress
//   adc_conversion_complete  : single-cycle completion pulse from the ADC
//   adc_value                : ADC result, valid only with adc_conversion_complete
//   adc_enable, adc_read     : ADC power-up and conversion request
//   busy                     : controller is working on a request
//   done, timeout            : one-cycle status pulses
//   result                   : last successfully captured value
module adc_read_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter bit          KEEP_ENABLED   = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       adc_conversion_complete,
  input  logic [ADC_VALUE_WIDTH-1:0] adc_value,
  output logic                       adc_enable,
  output logic                       adc_read,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic [ADC_VALUE_WIDTH-1:0] result
);

  localparam int unsigned CntMax = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES
                                                                    : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  // The counter is cleared on state entry, so the N-th edge in a state sees count N-1.
  localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  adc_ctrl_state_t            state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       adc_enable_q, adc_enable_d;
  logic                       adc_read_q, adc_read_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       timeout_q, timeout_d;
  logic [ADC_VALUE_WIDTH-1:0] result_q, result_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      adc_enable_q <= 1'b0;
      adc_read_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      adc_enable_q <= adc_enable_d;
      adc_read_q   <= adc_read_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      result_q     <= result_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CntW'(1);
    adc_enable_d = adc_enable_q;
    adc_read_d   = adc_read_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    timeout_d    = 1'b0;
    result_d     = result_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          adc_enable_d = 1'b1;
          busy_d       = 1'b1;
          // Skip settling when there is none, or when the ADC was left powered.
          if (SETTLE_CYCLES == 0 || (KEEP_ENABLED && adc_enable_q)) begin
            state_d    = READ;
            adc_read_d = 1'b1;
          end else begin
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = RECOVER;
        end else if (cnt_q == SettleLast) begin
          state_d    = READ;
          adc_read_d = 1'b1;
        end
      end
      READ: begin
        // Priority: abort over completion, completion over timeout.
        if (abort) begin
          state_d    = RECOVER;
          adc_read_d = 1'b0;
        end else if (adc_conversion_complete) begin
          state_d    = RECOVER;
          adc_read_d = 1'b0;
          result_d   = adc_value;
          done_d     = 1'b1;
        end else if (cnt_q == TimeoutLast) begin
          state_d    = RECOVER;
          adc_read_d = 1'b0;
          timeout_d  = 1'b1;
        end
      end
      RECOVER: begin
        // One guaranteed low cycle on adc_read before the next request can raise it.
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!KEEP_ENABLED) begin
          adc_enable_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  assign adc_enable = adc_enable_q;
  assign adc_read   = adc_read_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign result     = result_q;

endmodule

// File: tb/tb_adc_read_ctrl.sv
// Self-checking bench for adc_read_ctrl: a timestamp-based reference model checked every cycle,
// a behavioural ADC answering adc_read after a programmable delay, and directed scenarios with
// literal latency expectations.
module tb_adc_read_ctrl;

  localparam int unsigned S = 16;
  localparam int unsigned T = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort_tb = 1'b0;
  logic        abort_sync = 1'b0;
  logic        abort;
  logic        adc_cc = 1'b0;
  logic [15:0] adc_value = '0;
  logic        adc_enable, adc_read, busy, done, timeout;
  logic [15:0] result;

  assign abort = abort_tb | abort_sync;

  always #5 clk = ~clk;

  adc_read_ctrl #(
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(T),
    .KEEP_ENABLED  (1'b0)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .start                  (start),
    .abort                  (abort),
    .adc_conversion_complete(adc_cc),
    .adc_value              (adc_value),
    .adc_enable             (adc_enable),
    .adc_read               (adc_read),
    .busy                   (busy),
    .done                   (done),
    .timeout                (timeout),
    .result                 (result)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: timestamps of the edges where things must happen.
  int          cyc = 0;
  bit          m_en, m_rd, m_busy, m_done, m_to;
  logic [15:0] m_res = '0;
  int          read_at = -1, deadline = -1, release_at = -1;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_en = 0; m_rd = 0; m_busy = 0; m_done = 0; m_to = 0; m_res = '0;
      read_at = -1; deadline = -1; release_at = -1;
    end else begin
      cyc++;
      m_done = 0;
      m_to   = 0;
      if (release_at == cyc) begin
        m_busy = 0; m_en = 0; release_at = -1;
      end else if (m_busy) begin
        if (m_rd) begin
          if (abort) begin
            m_rd = 0; release_at = cyc + 1;
          end else if (adc_cc) begin
            m_res = adc_value; m_done = 1; m_rd = 0; release_at = cyc + 1;
          end else if (cyc == deadline) begin
            m_to = 1; m_rd = 0; release_at = cyc + 1;
          end
        end else if (read_at >= 0) begin
          if (abort) begin
            read_at = -1; release_at = cyc + 1;
          end else if (cyc == read_at) begin
            m_rd = 1; deadline = cyc + T; read_at = -1;
          end
        end
      end else if (start) begin
        m_busy = 1; m_en = 1; read_at = cyc + S;
      end
    end
  end

  // Behavioural ADC: answers a rising adc_read after adc_min..adc_max edges.
  int          adc_min = 10, adc_max = 200;
  bit          abort_on_cc = 0;
  bit          stray_req = 0;
  logic [15:0] last_valid = '0;
  int          cc_edge = -1;

  initial begin : adc_model
    bit pending = 0, prev_rd = 0, prev_stray = 0;
    int dcnt = 0;
    forever begin
      @(negedge clk);
      adc_cc     = 1'b0;
      abort_sync = 1'b0;
      adc_value  = 16'($urandom);
      if (!rst_n) begin
        pending = 0;
        prev_rd = 0;
      end else begin
        if (adc_read && !prev_rd) begin
          pending = 1;
          dcnt    = int'($urandom_range(adc_max, adc_min));
        end
        if (!adc_read) pending = 0;
        if (pending) begin
          if (dcnt <= 1) begin
            adc_cc     = 1'b1;
            adc_value  = 16'($urandom);
            last_valid = adc_value;
            cc_edge    = cyc + 1;
            pending    = 0;
            abort_sync = abort_on_cc;
          end else begin
            dcnt--;
          end
        end else if (stray_req && !prev_stray) begin
          adc_cc = 1'b1;
        end
        prev_rd = adc_read;
      end
      prev_stray = stray_req;
    end
  end

  // Per-cycle comparison plus edge bookkeeping for the directed checks.
  int read_rise_edge = -1, en_rise_edge = -1, done_edge = -1, to_edge = -1;
  int busy_fall_edge = -1;
  int n_rise = 0, n_done = 0, n_to = 0;

  initial begin : compare
    bit p_rd = 0, p_en = 0, p_busy = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("adc_enable", adc_enable, m_en);
        chk("adc_read", adc_read, m_rd);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("timeout", timeout, m_to);
        chk("result", result, m_res);
      end
      if (adc_read && !p_rd) begin read_rise_edge = cyc; n_rise++; end
      if (adc_enable && !p_en) en_rise_edge = cyc;
      if (!busy && p_busy) busy_fall_edge = cyc;
      if (done) begin done_edge = cyc; n_done++; end
      if (timeout) begin to_edge = cyc; n_to++; end
      p_rd = adc_read; p_en = adc_enable; p_busy = busy;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  int start_edge;

  task automatic do_read(input int budget);
    int n;
    start      = 1'b1;
    start_edge = cyc + 1;
    step();
    start = 1'b0;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk("busy_wait_bound", busy, 0);
  endtask

  task automatic check_normal(input string tag);
    chk({tag, "_done_edge"}, done_edge, cc_edge);
    chk({tag, "_busy_fall"}, busy_fall_edge, cc_edge + 1);
    chk({tag, "_result"}, result, last_valid);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] prev_res;
    int d0, t0, r0, n;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_adc_enable", adc_enable, 0);
    chk("rst_adc_read", adc_read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_result", result, 0);
    rst_n = 1'b1;
    repeat (6) step();

    // Slow reads with settling-latency literals.
    adc_min = 1000; adc_max = 2000;
    for (int i = 0; i < 3; i++) begin
      do_read(3000);
      chk("enable_edge", en_rise_edge, start_edge);
      chk("read_edge", read_rise_edge, start_edge + 16);
      check_normal("slow");
      step();
    end

    adc_min = 10; adc_max = 200;
    for (int i = 0; i < 100; i++) begin
      do_read(1000);
      check_normal("rand");
      if ((i % 3) == 0) step();
    end

    // Timeout: ADC never answers in time.
    adc_min = 5000; adc_max = 5000;
    prev_res = result; d0 = n_done; t0 = n_to;
    do_read(6000);
    chk("to_latency", to_edge - read_rise_edge, 4096);
    chk("to_result_kept", result, prev_res);
    chk("to_no_done", n_done, d0);
    chk("to_count", n_to, t0 + 1);

    // Abort 500 edges into READ.
    adc_min = 3000; adc_max = 3000;
    d0 = n_done; t0 = n_to; prev_res = result;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!adc_read && n < 100) begin
      step();
      n++;
    end
    chk("abort_read_seen", adc_read, 1);
    repeat (499) step();
    abort_tb = 1'b1;
    step();
    abort_tb = 1'b0;
    chk("abort_read_low", adc_read, 0);
    n = 0;
    while (busy && n < 10) begin
      step();
      n++;
    end
    chk("abort_busy_fall", busy_fall_edge, read_rise_edge + 501);
    chk("abort_no_done", n_done, d0);
    chk("abort_no_timeout", n_to, t0);
    chk("abort_result_kept", result, prev_res);
    adc_min = 10; adc_max = 50;
    do_read(500);
    check_normal("post_abort");

    // Abort coincident with completion: abort wins.
    adc_min = 50; adc_max = 50;
    abort_on_cc = 1; d0 = n_done; t0 = n_to; prev_res = result;
    do_read(500);
    abort_on_cc = 0;
    chk("abcc_no_done", n_done, d0);
    chk("abcc_no_timeout", n_to, t0);
    chk("abcc_result_kept", result, prev_res);

    // Completion on the exact timeout edge: completion wins.
    adc_min = 4096; adc_max = 4096;
    d0 = n_done; t0 = n_to;
    do_read(5000);
    chk("tocc_cc_latency", cc_edge - read_rise_edge, 4096);
    chk("tocc_done", n_done, d0 + 1);
    chk("tocc_no_timeout", n_to, t0);
    check_normal("tocc");

    // Stray completion pulse while idle is ignored.
    step();
    prev_res = result; d0 = n_done;
    stray_req = 1;
    repeat (3) step();
    stray_req = 0;
    chk("stray_result", result, prev_res);
    chk("stray_no_done", n_done, d0);

    // start held high: one adc_read rise per conversion.
    adc_min = 20; adc_max = 60;
    r0 = n_rise; d0 = n_done;
    start = 1'b1;
    repeat (600) step();
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk("hold_busy_bound", busy, 0);
    chk("hold_rise_per_done", n_rise - r0, n_done - d0);
    chk("hold_several_done", (n_done - d0) >= 5, 1);

    // Asynchronous reset in the middle of READ.
    adc_min = 100; adc_max = 200;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!adc_read && n < 100) begin
      step();
      n++;
    end
    repeat (5) step();
    chk("mid_result_nonzero", result != 0, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_adc_read", adc_read, 0);
    chk("arst_adc_enable", adc_enable, 0);
    chk("arst_busy", busy, 0);
    chk("arst_result", result, 0);
    chk("arst_done", done, 0);
    chk("arst_timeout", timeout, 0);
    step();
    rst_n = 1'b1;
    d0 = n_done; t0 = n_to;
    repeat (20) step();
    chk("post_rst_no_done", n_done, d0);
    chk("post_rst_no_timeout", n_to, t0);
    chk("post_rst_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
